// File: rtl/fetch_pc_unit.sv
//==============================================================================
// Module      : fetch_pc_unit
// Description : Fetch-stage program-counter generator. Drives the address of a
//               synchronous-read instruction memory and presents decode with a
//               PC/valid pair aligned to the word returned by that memory.
//               Handles hazard stalls, taken-branch/jump redirects with
//               wrong-path squash, and keeps a saturating redirect counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   RESET_PC      first fetch address after reset (word aligned)
//   CNT_W         width of the redirect counter
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous, active-high reset
//   stall         in   hazard hold; freezes fetch and decode-side registers
//   pcsel         in   execute-stage redirect (taken branch / JAL / JALR)
//   target        in   [31:0] redirect address from the ALU
//   imem_addr     out  [31:0] instruction-memory byte address (= pc_f)
//   pc_f          out  [31:0] PC currently being fetched
//   pc_d          out  [31:0] PC of the word now on the memory read port
//   valid_d       out  pc_d / instruction word are architecturally live
//   kill_d        out  combinational; decode squashes its current instruction
//   redirect_cnt  out  [CNT_W-1:0] accepted redirects, saturating
//   misalign      out  sticky misaligned-target flag
// Build options
//   MISALIGN_TRAP_EN  when defined, a redirect whose target has nonzero
//                     low bits sets the sticky misalign flag; otherwise the
//                     flag is constant 0 and no detection logic exists.
//==============================================================================
`default_nettype none

module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             pcsel,
  input  logic [31:0]      target,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc_f,
  output logic [31:0]      pc_d,
  output logic             valid_d,
  output logic             kill_d,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic             misalign
);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      C_PC_INC  = 32'd4;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_pc_f;
  logic [31:0]      r_pc_d;
  logic             r_valid_d;
  logic [31:0]      w_pc_f_nxt;
  logic [31:0]      w_pc_d_nxt;
  logic             w_valid_d_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_redirect;
  logic [31:0]      w_target_al;

  // Low bits are dropped so the fetch PC can never become misaligned.
  assign w_target_al = {target[31:2], 2'b00};

  // A redirect is only honoured once memory data is live (RUN).
  assign w_redirect = pcsel & (r_state == ST_RUN);

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state and next-PC logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_f_nxt    = r_pc_f;
    w_pc_d_nxt    = r_pc_d;
    w_valid_d_nxt = r_valid_d;
    case (r_state)
      ST_BOOT: begin
        // The reset PC was presented this cycle; its word arrives next cycle,
        // so fetch advances unconditionally and stall/pcsel are ignored.
        w_state_nxt   = ST_RUN;
        w_pc_f_nxt    = r_pc_f + C_PC_INC;
        w_pc_d_nxt    = r_pc_f;
        w_valid_d_nxt = 1'b1;
      end
      ST_RUN: begin
        if (pcsel) begin
          // Redirect beats stall. The word fetched at the old pc_f is on the
          // wrong path, so it lands in decode marked invalid.
          w_pc_f_nxt    = w_target_al;
          w_pc_d_nxt    = r_pc_f;
          w_valid_d_nxt = 1'b0;
        end else if (!stall) begin
          w_pc_f_nxt    = r_pc_f + C_PC_INC;
          w_pc_d_nxt    = r_pc_f;
          w_valid_d_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // PC / valid registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_f    <= RESET_PC;
      r_pc_d    <= 32'h0000_0000;
      r_valid_d <= 1'b0;
    end else begin
      r_pc_f    <= w_pc_f_nxt;
      r_pc_d    <= w_pc_d_nxt;
      r_valid_d <= w_valid_d_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // Saturating redirect counter
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_redirect && !(&r_cnt)) begin
      r_cnt <= r_cnt + C_CNT_ONE;
    end
  end

  //--------------------------------------------------------------------------
  // Misaligned-target detection
  //--------------------------------------------------------------------------
`ifdef MISALIGN_TRAP_EN
  logic r_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (w_redirect && (target[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  assign misalign = r_misalign;
`else
  logic w_unused_tgt_lsb;

  assign w_unused_tgt_lsb = ^target[1:0];
  assign misalign         = 1'b0;
`endif

  //--------------------------------------------------------------------------
  // Outputs
  //--------------------------------------------------------------------------
  assign imem_addr    = r_pc_f;
  assign pc_f         = r_pc_f;
  assign pc_d         = r_pc_d;
  assign valid_d      = r_valid_d;
  assign kill_d       = w_redirect;
  assign redirect_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
//==============================================================================
// Module      : tb_fetch_pc_unit
// Description : Self-checking bench for fetch_pc_unit. A directed vector table
//               walks reset/boot, sequential fetch, stall, redirects, stall
//               plus redirect, misaligned target, PC wrap and mid-run reset.
//               A randomized phase and a counter-saturation sequence are then
//               checked against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_pc_unit;

  localparam int          CNT_W    = 16;
  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;
`ifdef MISALIGN_TRAP_EN
  localparam logic        MIS_EN   = 1'b1;
`else
  localparam logic        MIS_EN   = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             stall;
  logic             pcsel;
  logic [31:0]      target;
  logic [31:0]      imem_addr;
  logic [31:0]      pc_f;
  logic [31:0]      pc_d;
  logic             valid_d;
  logic             kill_d;
  logic [CNT_W-1:0] redirect_cnt;
  logic             misalign;

  int n_checks = 0;
  int n_errors = 0;

  fetch_pc_unit #(
    .RESET_PC (RESET_PC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .pcsel        (pcsel),
    .target       (target),
    .imem_addr    (imem_addr),
    .pc_f         (pc_f),
    .pc_d         (pc_d),
    .valid_d      (valid_d),
    .kill_d       (kill_d),
    .redirect_cnt (redirect_cnt),
    .misalign     (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  //--------------------------------------------------------------------------
  // Behavioural model: architectural view of the fetch stage.
  //--------------------------------------------------------------------------
  logic [31:0] m_pc_f;
  logic [31:0] m_pc_d;
  logic        m_valid;
  int          m_cnt;
  logic        m_mis;
  logic        m_boot;   // first cycle after reset: memory data not yet live
  logic        m_known;  // model holds a defined state (a reset has occurred)

  initial m_known = 1'b0;

  task automatic model_edge();
    if (rst) begin
      m_pc_f  = RESET_PC;
      m_pc_d  = 32'h0;
      m_valid = 1'b0;
      m_cnt   = 0;
      m_mis   = 1'b0;
      m_boot  = 1'b1;
      m_known = 1'b1;
    end else if (m_boot) begin
      m_pc_d  = m_pc_f;
      m_pc_f  = m_pc_f + 32'd4;
      m_valid = 1'b1;
      m_boot  = 1'b0;
    end else if (pcsel) begin
      m_pc_d  = m_pc_f;
      m_pc_f  = target - (target % 4);
      m_valid = 1'b0;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (MIS_EN && (target % 4 != 0)) m_mis = 1'b1;
    end else if (!stall) begin
      m_pc_d  = m_pc_f;
      m_pc_f  = m_pc_f + 32'd4;
      m_valid = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " pc_f"},      pc_f,      m_pc_f);
    check({tag, " imem_addr"}, imem_addr, m_pc_f);
    check({tag, " pc_d"},      pc_d,      m_pc_d);
    check({tag, " valid_d"},   {31'h0, valid_d}, {31'h0, m_valid});
    check({tag, " kill_d"},    {31'h0, kill_d},  {31'h0, (pcsel & ~m_boot)});
    check({tag, " cnt"},       {{(32-CNT_W){1'b0}}, redirect_cnt}, m_cnt[31:0]);
    check({tag, " misalign"},  {31'h0, misalign}, {31'h0, m_mis});
  endtask

  // Drive inputs just after a falling edge, let combinational outputs settle.
  task automatic drive(input logic r, input logic s, input logic p, input logic [31:0] t);
    rst    = r;
    stall  = s;
    pcsel  = p;
    target = t;
    #1;
  endtask

  // Cross the rising edge, update the model, return to the falling edge.
  task automatic advance();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  //--------------------------------------------------------------------------
  // Directed vector table: inputs applied in a cycle and the outputs
  // expected in that same cycle (before the edge that samples the inputs).
  //--------------------------------------------------------------------------
  typedef struct {
    logic        r;
    logic        s;
    logic        p;
    logic [31:0] t;
    logic        chk;
    logic [31:0] pcf;
    logic [31:0] pcd;
    logic        v;
    logic        k;
    logic [15:0] cnt;
    logic        mis;   // misalign expected when the trap option is built
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 16'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_0000, 32'h0,         1'b0, 1'b0, 16'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_0000, 32'h0,         1'b0, 1'b0, 16'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_0000, 32'h0,         1'b0, 1'b0, 16'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_0004, 32'h4000_0000, 1'b1, 1'b0, 16'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_0008, 32'h4000_0004, 1'b1, 1'b0, 16'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_000C, 32'h4000_0008, 1'b1, 1'b0, 16'd0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4000_0010, 32'h4000_000C, 1'b1, 1'b0, 16'd0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4000_0010, 32'h4000_000C, 1'b1, 1'b0, 16'd0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h4000_0100, 1'b1, 32'h4000_0010, 32'h4000_000C, 1'b1, 1'b1, 16'd0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_0100, 32'h4000_0010, 1'b0, 1'b0, 16'd1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_0104, 32'h4000_0100, 1'b1, 1'b0, 16'd1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'h4000_0200, 1'b1, 32'h4000_0108, 32'h4000_0104, 1'b1, 1'b1, 16'd1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_0200, 32'h4000_0108, 1'b0, 1'b0, 16'd2, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 32'h4000_0303, 1'b1, 32'h4000_0204, 32'h4000_0200, 1'b1, 1'b1, 16'd2, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_0300, 32'h4000_0204, 1'b0, 1'b0, 16'd3, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h4000_0304, 32'h4000_0300, 1'b1, 1'b1, 16'd3, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h4000_0304, 1'b0, 1'b0, 16'd4, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 1'b0, 16'd4, 1'b1};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 32'h0000_0123, 1'b1, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b1, 16'd4, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 1'b1, 32'h0000_0500, 1'b1, 32'h4000_0000, 32'h0,         1'b0, 1'b0, 16'd0, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4000_0004, 32'h4000_0000, 1'b1, 1'b0, 16'd0, 1'b0};
  end

  //--------------------------------------------------------------------------
  // Test sequence
  //--------------------------------------------------------------------------
  initial begin
    rst    = 1'b1;
    stall  = 1'b0;
    pcsel  = 1'b0;
    target = 32'h0;
    #0;

    // Directed table
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].t);
      if (tbl[i].chk) begin
        check($sformatf("vec%0d pc_f", i),      pc_f,      tbl[i].pcf);
        check($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].pcf);
        check($sformatf("vec%0d pc_d", i),      pc_d,      tbl[i].pcd);
        check($sformatf("vec%0d valid_d", i),   {31'h0, valid_d}, {31'h0, tbl[i].v});
        check($sformatf("vec%0d kill_d", i),    {31'h0, kill_d},  {31'h0, tbl[i].k});
        check($sformatf("vec%0d cnt", i),       {16'h0, redirect_cnt}, {16'h0, tbl[i].cnt});
        check($sformatf("vec%0d misalign", i),  {31'h0, misalign}, {31'h0, (tbl[i].mis & MIS_EN)});
      end
      advance();
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(63) == 0),
            ($urandom_range(2) == 0),
            ($urandom_range(4) == 0),
            $urandom);
      check_model($sformatf("rnd%0d", i));
      advance();
    end

    // Counter saturation: 2^CNT_W + 3 back-to-back redirects
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    advance();
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h4000_1000 + (i[5:0] * 32'd4));
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("sat cnt", {16'h0, redirect_cnt}, 32'h0000_FFFF);
    check_model("sat");
    advance();

    // Wrap through a redirect to the last word of the address space
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap pre pc_f", pc_f, 32'hFFFF_FFFC);
    check("wrap sticky cnt", {16'h0, redirect_cnt}, 32'h0000_FFFF);
    advance();
    check("wrap pc_f", pc_f, 32'h0000_0000);
    check("wrap pc_d", pc_d, 32'hFFFF_FFFC);
    check("wrap misalign", {31'h0, misalign}, {31'h0, MIS_EN});
    check_model("wrap");
    advance();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
